sprite_layer_scheduler: RTL
===========================

// Module: sprite_layer_scheduler
// PURPOSE
//  Time-multiplexes a single sprite_storage lookup port between NUM_LAYERS sprite layers for each
//  VGA pixel. On each pixel request it issues one lookup per enabled layer in priority order.
//  It returns the first non-transparent colour, or BG_COLOR if every layer is transparent.
//  Sits between the VGA pixel-coordinate source and the shared sprite storage ROM.
// PARAMETERS
//  NUM_LAYERS   4      number of sprite layers; layer 0 = highest priority
//  TRANSPARENT  8'hFF  storage colour treated as "no pixel"
//  BG_COLOR     8'h00  colour output when no enabled layer is opaque
// PORTS
//  clk             in   1              system clock; all logic on posedge
//  resetN          in   1              asynchronous, active-low reset
//  pixel_start     in   1              request pulse; pixelX/pixelY/layer_* sampled with it
//  pixelX          in   32 (int)       requested screen x
//  pixelY          in   32 (int)       requested screen y
//  layer_enable    in   NUM_LAYERS     per-layer enable; bit i = layer i
//  layer_sprite    in   NUM_LAYERS x32 sprite number per layer
//  layer_x_offset  in   NUM_LAYERS x32 x offset per layer
//  layer_y_offset  in   NUM_LAYERS x32 y offset per layer
//  sprite_number   out  32             storage request: sprite select
//  requested_x     out  32             storage request: x (= latched pixelX)
//  requested_y     out  32             storage request: y (= latched pixelY)
//  x_offset        out  32             storage request: x offset of current layer
//  y_offset        out  32             storage request: y offset of current layer
//  storage_RGB     in   8              storage RGBout; valid 1 cycle after request
//  RGBout          out  8              resolved pixel colour
//  pixel_valid     out  1              1-cycle strobe; RGBout valid for this pixel
//  busy            out  1              high while a pixel is in progress
//  dropped         out  1              1-cycle strobe; pixel_start ignored because busy
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (RGBout=0, request ports=0, pixel_valid=busy=dropped=0).
//   Asserting reset mid-pixel aborts the pixel; no pixel_valid is produced for it.
//  FSM states: IDLE -> ISSUE -> (DRAIN) -> IDLE.
//  - IDLE:
//    - pixel_start=1 latches coords, enable mask and layer config (changes after this don't matter).
//    - busy<=1. Go to ISSUE, or emit BG_COLOR directly if layer_enable==0.
//  - ISSUE:
//    - One enabled layer per cycle, ascending index; disabled layers are skipped (no bubble).
//    - Request ports are registered and hold their last value when not issuing.
//  - DRAIN: waits for the last result after the final issue.
//  - Each returned storage_RGB is tagged with its layer.
//    - First result != TRANSPARENT = winner; early-out, and any in-flight result after it is discarded.
//  Latency, with pixel_start sampled at edge E0, k = number of enabled layers,
//  and j = position of the winner among enabled layers (0-based):
//    - winner at position j: pixel_valid=1 after edge E(j+2), RGBout = winner colour.
//    - no winner:            pixel_valid=1 after E(k+1), RGBout = BG_COLOR.
//    - k=0:                  pixel_valid=1 after E1, RGBout = BG_COLOR.
//  Completion edge: pixel_valid=1 for exactly one cycle, busy=0 and state=IDLE on the same edge.
//  RGBout holds its value until the next completion.
//  pixel_start sampled while busy=1: ignored; dropped=1 for the next cycle; in-progress pixel unaffected.
//  Offsets and coordinates pass through unmodified (no arithmetic); wrap is the storage's concern.
// TESTING
//  1. Reset, all layers enabled, storage returns 8'h15 for layer 0
//     -> RGBout=8'h15, pixel_valid exactly 2 cycles after start, 1 cycle wide.
//  2. Enable=4'b1111, layers 0,1 return 8'hFF, layer 2 returns 8'h92
//     -> RGBout=8'h92 at E4; layer 3 result never used.
//  3. Enable=4'b1010, both layers transparent -> requests only for layers 1,3; RGBout=8'h00 at E3.
//  4. Enable=0 -> RGBout=BG_COLOR at E1; no sprite_number change on request ports.
//  5. pixel_start again at E1 while busy -> dropped=1 one cycle; first pixel completes normally;
//     a start on the cycle after completion is accepted.
//  6. resetN low at E2 of a 4-layer request -> all outputs 0 asynchronously;
//     no pixel_valid; next pixel_start processed normally.

Source files
------------

// File: rtl/sprite_layer_scheduler.sv
// Per-pixel arbiter that shares one sprite_storage lookup port between NUM_LAYERS layers,
// resolving the first opaque colour in priority order (layer 0 first) or BG_COLOR.
module sprite_layer_scheduler #(
  parameter int          NUM_LAYERS  = 4,
  parameter logic [7:0]  TRANSPARENT = 8'hFF,
  parameter logic [7:0]  BG_COLOR    = 8'h00
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         pixel_start,
  input  logic [31:0]                  pixelX,
  input  logic [31:0]                  pixelY,
  input  logic [NUM_LAYERS-1:0]        layer_enable,
  input  logic [NUM_LAYERS-1:0][31:0]  layer_sprite,
  input  logic [NUM_LAYERS-1:0][31:0]  layer_x_offset,
  input  logic [NUM_LAYERS-1:0][31:0]  layer_y_offset,
  output logic [31:0]                  sprite_number,
  output logic [31:0]                  requested_x,
  output logic [31:0]                  requested_y,
  output logic [31:0]                  x_offset,
  output logic [31:0]                  y_offset,
  input  logic [7:0]                   storage_RGB,
  output logic [7:0]                   RGBout,
  output logic                         pixel_valid,
  output logic                         busy,
  output logic                         dropped,
  output logic [1:0]                   state_o
);

  localparam int IDXW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_e;

  // Handshake: pixel_start is a single-cycle request accepted only while busy is low
  // (otherwise dropped strobes); pixel_valid is a one-cycle strobe with no backpressure.

  state_e                        state_q;
  logic [NUM_LAYERS-1:0]         pend_q;
  logic [NUM_LAYERS-1:0][31:0]   lay_sprite_q, lay_x_q, lay_y_q;
  logic [31:0]                   sprite_q, req_x_q, req_y_q, x_off_q, y_off_q;
  logic [7:0]                    rgb_q;
  logic                          valid_q, busy_q, dropped_q;
  logic                          iss_v_q, iss_last_q, res_v_q, res_last_q;

  logic [NUM_LAYERS-1:0]         src_mask, rest_mask;
  logic [IDXW-1:0]               sel;
  logic [31:0]                   sel_sprite, sel_x, sel_y;
  logic                          res_hit, done;
  logic [7:0]                    done_rgb;

  function automatic logic [IDXW-1:0] first_idx(input logic [NUM_LAYERS-1:0] m);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (m[i]) r = IDXW'(i);
    end
    return r;
  endfunction

  // In IDLE the first request is built straight from the inputs, since the latch happens on the same edge.
  always_comb begin
    src_mask   = (state_q == IDLE) ? layer_enable : pend_q;
    sel        = first_idx(src_mask);
    rest_mask  = src_mask & (src_mask - NUM_LAYERS'(1));
    sel_sprite = (state_q == IDLE) ? layer_sprite[sel]   : lay_sprite_q[sel];
    sel_x      = (state_q == IDLE) ? layer_x_offset[sel] : lay_x_q[sel];
    sel_y      = (state_q == IDLE) ? layer_y_offset[sel] : lay_y_q[sel];
    res_hit    = res_v_q && (storage_RGB != TRANSPARENT);
    done       = (state_q != IDLE) &&
                 ((res_v_q && (res_hit || res_last_q)) ||
                  (state_q == DRAIN && !res_v_q && !iss_v_q));
    done_rgb   = res_hit ? storage_RGB : BG_COLOR;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      lay_sprite_q <= '0;
      lay_x_q      <= '0;
      lay_y_q      <= '0;
      sprite_q     <= '0;
      req_x_q      <= '0;
      req_y_q      <= '0;
      x_off_q      <= '0;
      y_off_q      <= '0;
      rgb_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      dropped_q    <= 1'b0;
      iss_v_q      <= 1'b0;
      iss_last_q   <= 1'b0;
      res_v_q      <= 1'b0;
      res_last_q   <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      dropped_q  <= pixel_start && (state_q != IDLE);
      iss_v_q    <= 1'b0;
      iss_last_q <= 1'b0;
      res_v_q    <= iss_v_q;
      res_last_q <= iss_last_q;
      if (done) begin
        // Early-out: anything still in flight belongs to a lower-priority layer and is discarded.
        state_q <= IDLE;
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
        rgb_q   <= done_rgb;
        pend_q  <= '0;
        res_v_q <= 1'b0;
      end else if ((state_q == IDLE && pixel_start) || state_q == ISSUE) begin
        if (state_q == IDLE) begin
          busy_q       <= 1'b1;
          lay_sprite_q <= layer_sprite;
          lay_x_q      <= layer_x_offset;
          lay_y_q      <= layer_y_offset;
          req_x_q      <= pixelX;
          req_y_q      <= pixelY;
        end
        if (src_mask == '0) begin
          state_q <= DRAIN;
        end else begin
          sprite_q   <= sel_sprite;
          x_off_q    <= sel_x;
          y_off_q    <= sel_y;
          iss_v_q    <= 1'b1;
          iss_last_q <= (rest_mask == '0);
          pend_q     <= rest_mask;
          state_q    <= (rest_mask == '0) ? DRAIN : ISSUE;
        end
      end
    end
  end

  assign sprite_number = sprite_q;
  assign requested_x   = req_x_q;
  assign requested_y   = req_y_q;
  assign x_offset      = x_off_q;
  assign y_offset      = y_off_q;
  assign RGBout        = rgb_q;
  assign pixel_valid   = valid_q;
  assign busy          = busy_q;
  assign dropped       = dropped_q;
  assign state_o       = state_q;

endmodule
